bcd_countdown_timer: RTL and testbench

//  - Parametrised N-digit BCD countdown timer; successor to the fixed two-digit borrow-chain timer.
//  - Adds an internal tick prescaler, start/pause control, auto-reload mode, load validation and an expiry pulse.
//  - Sits between the front-panel switch/button logic and the seven-segment decoders.
//  - One digit_out nibble feeds one decoder.

---
 rtl/timer_pkg.sv | 20 ++
 rtl/bcd_down_digit.sv | 39 +++
 rtl/bcd_countdown_timer.sv | 227 ++++++++++++++++++++++
 tb/tb_bcd_countdown_timer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the BCD countdown timer.
//   timer_state_e : FSM state encoding (IDLE, RUN, PAUSED, EXPIRED)
//   BCD_MAX       : largest legal BCD digit value
//   is_bcd()      : returns 1 when a nibble holds a legal BCD digit
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } timer_state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic is_bcd(input logic [3:0] nibble);
    return (nibble <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the countdown chain.
// Ports:
//   clock, reset       : system clock, asynchronous active-low reset
//   load, load_val     : synchronous load of a BCD value (wins over dec)
//   dec, borrow_in     : decrement request and borrow from the less significant digit
//   value              : current digit value
//   borrow_out         : this digit wraps 0 -> 9 and borrows from the next digit
module bcd_down_digit
  import timer_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  input  logic       borrow_in,
  output logic [3:0] value,
  output logic       borrow_out
);

  logic [3:0] value_r;

  // Digit register: load, borrow-driven decrement with 0 -> 9 wrap, else hold.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value_r <= 4'd0;
    end else if (load) begin
      value_r <= load_val;
    end else if (dec && borrow_in) begin
      value_r <= (value_r == 4'd0) ? BCD_MAX : (value_r - 4'd1);
    end else begin
      value_r <= value_r;
    end
  end

  assign value      = value_r;
  assign borrow_out = dec && borrow_in && (value_r == 4'd0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// N-digit BCD countdown timer with tick prescaler, start/pause control,
// auto-reload and load validation.
// Ports:
//   clock        : system clock, rising edge
//   reset        : asynchronous active-low reset, clears all state
//   reconfigure  : load request, samples load_digits
//   load_digits  : BCD preset, nibble i is digit i
//   start        : start, or restart after expiry
//   pause        : toggles RUN <-> PAUSED once per asserted cycle
//   auto_reload  : reload preset after reaching zero and keep running
//   digit_out    : current count (BCD)
//   running      : high in RUN
//   clockout     : one-cycle pulse when a decrement lands on zero
//   expired      : high in EXPIRED
//   load_error   : one-cycle pulse after a reconfigure with a non-BCD nibble
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int TICK_DIV   = 50
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    reconfigure,
  input  logic [4*NUM_DIGITS-1:0] load_digits,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    auto_reload,
  output logic [4*NUM_DIGITS-1:0] digit_out,
  output logic                    running,
  output logic                    clockout,
  output logic                    expired,
  output logic                    load_error
);

  localparam int W  = 4 * NUM_DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

  timer_state_e  state_r, state_nxt_s;
  logic [PW-1:0] prescaler_r, prescaler_nxt_s;
  logic [W-1:0]  shadow_r, shadow_nxt_s;
  logic          reload_pend_r, reload_pend_nxt_s;
  logic          clockout_r, clockout_nxt_s;
  logic          load_error_r, load_error_nxt_s;
  logic          running_r, expired_r;

  logic [W-1:0]  count_s;
  logic          dig_load_s, dig_dec_s;
  logic [W-1:0]  dig_val_s;
  logic          valid_s, tick_s, count_zero_s, count_one_s;
  logic [NUM_DIGITS-1:0] borrow_s;
  logic          borrow_unused_s;

  // Validation: every nibble of the requested preset must be a BCD digit.
  always_comb begin
    valid_s = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!is_bcd(load_digits[4*i +: 4])) begin
        valid_s = 1'b0;
      end else begin
        valid_s = valid_s;
      end
    end
  end

  assign tick_s       = (state_r == RUN) && (prescaler_r == PS_LAST);
  assign count_zero_s = (count_s == W'(0));
  assign count_one_s  = (count_s == W'(1));

  // FSM next-state and datapath control; priority reconfigure > start > pause > tick.
  always_comb begin
    state_nxt_s       = state_r;
    prescaler_nxt_s   = prescaler_r;
    shadow_nxt_s      = shadow_r;
    reload_pend_nxt_s = reload_pend_r;
    clockout_nxt_s    = 1'b0;
    load_error_nxt_s  = 1'b0;
    dig_load_s        = 1'b0;
    dig_val_s         = shadow_r;
    dig_dec_s         = 1'b0;

    if (reconfigure) begin
      // An invalid preset also swallows any start/pause in the same cycle.
      if (valid_s) begin
        dig_load_s        = 1'b1;
        dig_val_s         = load_digits;
        shadow_nxt_s      = load_digits;
        prescaler_nxt_s   = PW'(0);
        reload_pend_nxt_s = 1'b0;
        state_nxt_s       = IDLE;
      end else begin
        load_error_nxt_s  = 1'b1;
      end
    end else if (start) begin
      case (state_r)
        IDLE: begin
          if (count_zero_s) begin
            state_nxt_s     = EXPIRED;
          end else begin
            state_nxt_s     = RUN;
            prescaler_nxt_s = PW'(0);
          end
        end
        EXPIRED: begin
          dig_load_s        = 1'b1;
          prescaler_nxt_s   = PW'(0);
          reload_pend_nxt_s = 1'b0;
          state_nxt_s       = (shadow_r != W'(0)) ? RUN : EXPIRED;
        end
        RUN, PAUSED: begin
          state_nxt_s = state_r;
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end else if (pause) begin
      case (state_r)
        RUN: begin
          // The pause cycle still counts as enabled, but a pending tick is
          // never consumed here: the prescaler saturates at its last value
          // so the deferred tick fires on the first cycle after resume.
          state_nxt_s     = PAUSED;
          prescaler_nxt_s = (prescaler_r == PS_LAST) ? prescaler_r : (prescaler_r + PW'(1));
        end
        PAUSED: begin
          state_nxt_s = RUN;
        end
        IDLE, EXPIRED: begin
          state_nxt_s = state_r;
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end else if (tick_s) begin
      prescaler_nxt_s = PW'(0);
      if (reload_pend_r) begin
        // Zero has been shown for one full tick period; restore the preset.
        dig_load_s        = 1'b1;
        reload_pend_nxt_s = 1'b0;
      end else begin
        dig_dec_s = 1'b1;
        if (count_one_s) begin
          clockout_nxt_s = 1'b1;
          if (auto_reload && (shadow_r != W'(0))) begin
            reload_pend_nxt_s = 1'b1;
          end else begin
            state_nxt_s = EXPIRED;
          end
        end else begin
          clockout_nxt_s = 1'b0;
        end
      end
    end else if (state_r == RUN) begin
      prescaler_nxt_s = prescaler_r + PW'(1);
    end else begin
      prescaler_nxt_s = prescaler_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Prescaler, shadow preset and registered status outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prescaler_r   <= PW'(0);
      shadow_r      <= W'(0);
      reload_pend_r <= 1'b0;
      clockout_r    <= 1'b0;
      load_error_r  <= 1'b0;
      running_r     <= 1'b0;
      expired_r     <= 1'b0;
    end else begin
      prescaler_r   <= prescaler_nxt_s;
      shadow_r      <= shadow_nxt_s;
      reload_pend_r <= reload_pend_nxt_s;
      clockout_r    <= clockout_nxt_s;
      load_error_r  <= load_error_nxt_s;
      running_r     <= (state_nxt_s == RUN);
      expired_r     <= (state_nxt_s == EXPIRED);
    end
  end

  // Digit chain: digit 0 always sees a borrow, each digit borrows into the next.
  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : gen_digit
      logic borrow_in_s;
      logic borrow_out_s;
      if (g == 0) begin : gen_lsb
        assign borrow_in_s = 1'b1;
      end else begin : gen_upper
        assign borrow_in_s = borrow_s[g-1];
      end
      bcd_down_digit u_digit (
        .clock      (clock),
        .reset      (reset),
        .load       (dig_load_s),
        .load_val   (dig_val_s[4*g +: 4]),
        .dec        (dig_dec_s),
        .borrow_in  (borrow_in_s),
        .value      (count_s[4*g +: 4]),
        .borrow_out (borrow_out_s)
      );
      assign borrow_s[g] = borrow_out_s;
    end
  endgenerate

  // The MSB borrow would mean underflow, which the FSM never allows.
  assign borrow_unused_s = borrow_s[NUM_DIGITS-1];

  assign digit_out  = count_s;
  assign running    = running_r;
  assign clockout   = clockout_r;
  assign expired    = expired_r;
  assign load_error = load_error_r;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
module tb_bcd_countdown_timer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: 2 digits, DUT B: 3 digits, both with a 4-cycle tick.
  logic       rst_a, a_rc, a_st, a_pa, a_ar;
  logic [7:0] a_ld, a_dig;
  logic       a_run, a_co, a_exp, a_le;

  logic        rst_b, b_rc, b_st, b_pa, b_ar;
  logic [11:0] b_ld, b_dig;
  logic        b_run, b_co, b_exp, b_le;

  bcd_countdown_timer #(.NUM_DIGITS(2), .TICK_DIV(4)) dut_a (
    .clock(clk), .reset(rst_a), .reconfigure(a_rc), .load_digits(a_ld),
    .start(a_st), .pause(a_pa), .auto_reload(a_ar), .digit_out(a_dig),
    .running(a_run), .clockout(a_co), .expired(a_exp), .load_error(a_le)
  );

  bcd_countdown_timer #(.NUM_DIGITS(3), .TICK_DIV(4)) dut_b (
    .clock(clk), .reset(rst_b), .reconfigure(b_rc), .load_digits(b_ld),
    .start(b_st), .pause(b_pa), .auto_reload(b_ar), .digit_out(b_dig),
    .running(b_run), .clockout(b_co), .expired(b_exp), .load_error(b_le)
  );

  typedef struct {
    int          cyc;
    int          d;
    logic [11:0] dg;
    logic        r;
    logic        e;
    logic        c;
    logic        l;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops every expectation due at this cycle and compares it.
  always @(negedge clk) begin
    exp_t        x;
    logic [15:0] act;
    logic [15:0] want;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      x = sb.pop_front();
      if (x.d == 0) act = {4'h0, a_dig, a_run, a_exp, a_co, a_le};
      else          act = {b_dig, b_run, b_exp, b_co, b_le};
      want = {x.dg, x.r, x.e, x.c, x.l};
      total = total + 1;
      if (act !== want || x.cyc != cyc) begin
        bad = bad + 1;
        $display("FAIL chk dut%0d cyc=%0d(due %0d) got dig=%h run=%b exp=%b co=%b le=%b want dig=%h run=%b exp=%b co=%b le=%b",
                 x.d, cyc, x.cyc, act[15:4], act[3], act[2], act[1], act[0],
                 want[15:4], want[3], want[2], want[1], want[0]);
      end
    end
  end

  function automatic logic [11:0] bcd(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // Queue the expectation for the next edge, then advance one cycle.
  task automatic tick_chk(input int d, input logic [11:0] dg,
                          input logic r, input logic e, input logic c, input logic l);
    sb.push_back('{cyc + 1, d, dg, r, e, c, l});
    @(posedge clk);
    #2;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog cyc=%0d pending=%0d", cyc, sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b0; a_rc = 1'b0; a_st = 1'b0; a_pa = 1'b0; a_ar = 1'b0; a_ld = 8'h00;
    rst_b = 1'b0; b_rc = 1'b0; b_st = 1'b0; b_pa = 1'b0; b_ar = 1'b0; b_ld = 12'h000;
    repeat (2) @(posedge clk);
    #2;
    rst_a = 1'b1;
    rst_b = 1'b1;

    // Reset state
    tick_chk(0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick_chk(1, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Load 12, then a non-BCD load leaves it untouched
    a_rc = 1'b1; a_ld = 8'h12;
    tick_chk(0, 12'h012, 1'b0, 1'b0, 1'b0, 1'b0);
    a_ld = 8'h1A;
    tick_chk(0, 12'h012, 1'b0, 1'b0, 1'b0, 1'b1);
    a_rc = 1'b0;
    tick_chk(0, 12'h012, 1'b0, 1'b0, 1'b0, 1'b0);

    // Full countdown 12 -> 00, one decrement every 4 cycles
    a_st = 1'b1;
    tick_chk(0, 12'h012, 1'b1, 1'b0, 1'b0, 1'b0);
    a_st = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      int v;
      v = (c < 48) ? (12 - c / 4) : 0;
      tick_chk(0, bcd(v), c < 48, c >= 48, c == 48, 1'b0);
    end

    // Restart from EXPIRED reloads the preset
    a_st = 1'b1;
    tick_chk(0, 12'h012, 1'b1, 1'b0, 1'b0, 1'b0);
    a_st = 1'b0;

    // Load 00 and start: expired without clockout
    a_rc = 1'b1; a_ld = 8'h00;
    tick_chk(0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    a_rc = 1'b0; a_st = 1'b1;
    tick_chk(0, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    a_st = 1'b0;
    tick_chk(0, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0);

    // Auto-reload: 02,01,00(pulse),02,01,00(pulse),02
    a_ar = 1'b1; a_rc = 1'b1; a_ld = 8'h02;
    tick_chk(0, 12'h002, 1'b0, 1'b0, 1'b0, 1'b0);
    a_rc = 1'b0; a_st = 1'b1;
    tick_chk(0, 12'h002, 1'b1, 1'b0, 1'b0, 1'b0);
    a_st = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      int p;
      p = (c / 4) % 3;
      tick_chk(0, bcd((p == 0) ? 2 : ((p == 1) ? 1 : 0)), 1'b1, 1'b0,
               (c % 4 == 0) && (p == 2), 1'b0);
    end

    // Pause sampled at prescaler=2 freezes the count; resume ticks after one enabled cycle
    a_ar = 1'b0; a_rc = 1'b1; a_ld = 8'h12;
    tick_chk(0, 12'h012, 1'b0, 1'b0, 1'b0, 1'b0);
    a_rc = 1'b0; a_st = 1'b1;
    tick_chk(0, 12'h012, 1'b1, 1'b0, 1'b0, 1'b0);
    a_st = 1'b0;
    tick_chk(0, 12'h012, 1'b1, 1'b0, 1'b0, 1'b0);
    tick_chk(0, 12'h012, 1'b1, 1'b0, 1'b0, 1'b0);
    a_pa = 1'b1;
    tick_chk(0, 12'h012, 1'b0, 1'b0, 1'b0, 1'b0);
    a_pa = 1'b0;
    repeat (5) tick_chk(0, 12'h012, 1'b0, 1'b0, 1'b0, 1'b0);
    a_pa = 1'b1;
    tick_chk(0, 12'h012, 1'b1, 1'b0, 1'b0, 1'b0);
    a_pa = 1'b0;
    tick_chk(0, 12'h011, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) tick_chk(0, 12'h011, 1'b1, 1'b0, 1'b0, 1'b0);
    tick_chk(0, 12'h010, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reconfigure + start while running: new value, IDLE, no decrement
    a_rc = 1'b1; a_st = 1'b1; a_ld = 8'h45;
    tick_chk(0, 12'h045, 1'b0, 1'b0, 1'b0, 1'b0);
    a_rc = 1'b0; a_st = 1'b0;
    repeat (5) tick_chk(0, 12'h045, 1'b0, 1'b0, 1'b0, 1'b0);

    // 3 digits: 100 -> 099 with borrow ripple
    b_rc = 1'b1; b_ld = 12'h100;
    tick_chk(1, 12'h100, 1'b0, 1'b0, 1'b0, 1'b0);
    b_rc = 1'b0; b_st = 1'b1;
    tick_chk(1, 12'h100, 1'b1, 1'b0, 1'b0, 1'b0);
    b_st = 1'b0;
    repeat (3) tick_chk(1, 12'h100, 1'b1, 1'b0, 1'b0, 1'b0);
    tick_chk(1, 12'h099, 1'b1, 1'b0, 1'b0, 1'b0);
    tick_chk(1, 12'h099, 1'b1, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-count: outputs clear before any further edge
    @(posedge clk);
    #2;
    rst_b = 1'b0;
    sb.push_back('{cyc, 1, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0});
    @(posedge clk);
    #2;
    rst_b = 1'b1;
    tick_chk(1, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    b_st = 1'b1;
    tick_chk(1, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    b_st = 1'b0;

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      $display("FAIL drain pending=%0d required=0", sb.size());
      bad = bad + sb.size();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
